tx_block_serializer: RTL and testbench

- Transmit-side buffer on the path from the AES control logic back to the host.
- Accepts 128-bit ciphertext blocks through a write/overflow handshake and queues them in a FIFO of blocks.
- Serializes each block into 16 bytes, most-significant byte first, for the byte-wide UART transmitter.
- Provides the tx_write / tx_overflow / ct interface that the control block drives.

---
 rtl/comms_pkg.sv | 17 +
 rtl/block_fifo.sv | 69 ++++++
 rtl/tx_block_serializer.sv | 144 ++++++++++++++
 tb/tb_tx_block_serializer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comms_pkg.sv
// Shared definitions for the transmit path: block/byte geometry and the
// serializer state encoding used by tx_block_serializer.
package comms_pkg;

  localparam int BLOCK_W         = 128;
  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_BLOCK = 16;
  localparam int IDX_W           = $clog2(BYTES_PER_BLOCK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2,
    WAIT = 2'd3
  } ser_state_e;

endpackage

// File: rtl/block_fifo.sv
// DEPTH x 128-bit synchronous FIFO of ciphertext blocks.
// Push is refused while full and pop is ignored while empty; both are judged
// against the pre-edge count, so a push on a full FIFO is refused even when a
// pop happens in the same cycle.
import comms_pkg::*;

module block_fifo #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic [BLOCK_W-1:0] wdata_i,
  output logic [BLOCK_W-1:0] head_o,
  output logic [PTR_W:0]     count_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [BLOCK_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               pushOk;
  logic               popOk;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;
  assign pushOk  = push_i && !full_o;
  assign popOk   = pop_i && !empty_o;

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushOk) wrPtr_d = wrPtr_q + PTR_ONE;
    if (popOk)  rdPtr_d = rdPtr_q + PTR_ONE;
    if (pushOk && !popOk)      count_d = count_q + CNT_ONE;
    else if (popOk && !pushOk) count_d = count_q - CNT_ONE;
  end

  // Pointer and count registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Block storage; contents are only meaningful once written, so no reset.
  always_ff @(posedge clk) begin
    if (pushOk) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/tx_block_serializer.sv
// Transmit-side block buffer: queues 128-bit ciphertext blocks and feeds
// them MSB byte first to a byte-wide UART using a start/busy handshake.
// Optional feature macro: TX_DROP_COUNT_EN adds a saturating counter of
// writes refused because the FIFO was full.
import comms_pkg::*;

module tx_block_serializer #(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BLOCK_W-1:0] ct,
  input  logic               tx_write,
  output logic               tx_overflow,
  output logic [BYTE_W-1:0]  uart_data,
  output logic               uart_start,
  input  logic               uart_busy,
  output logic               tx_idle
`ifdef TX_DROP_COUNT_EN
  ,
  output logic [15:0]        drop_count
`endif
);

  localparam logic [PTR_W:0]   ALMOST_CNT = (PTR_W+1)'(DEPTH-1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BYTES_PER_BLOCK-1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  ser_state_e         state_q, state_d;
  logic [BLOCK_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]   byteIdx_q, byteIdx_d;
  logic [BYTE_W-1:0]  uartData_q, uartData_d;
  logic               uartStart_q, uartStart_d;
  logic               overflow_q, overflow_d;

  logic               fifoPop;
  logic [BLOCK_W-1:0] fifoHead;
  logic [PTR_W:0]     fifoCount;
  logic               fifoFull;
  logic               fifoEmpty;

  block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (tx_write),
    .pop_i   (fifoPop),
    .wdata_i (ct),
    .head_o  (fifoHead),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign tx_overflow = overflow_q;
  assign uart_data   = uartData_q;
  assign uart_start  = uartStart_q;
  assign tx_idle     = fifoEmpty && (state_q == IDLE);

  // Serializer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Serializer next-state: pop a block, then per byte LOAD -> ACK -> WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!fifoEmpty) state_d = LOAD;
      LOAD: if (!uart_busy) state_d = ACK;
      ACK:  state_d = WAIT;
      WAIT: if (!uart_busy) state_d = (byteIdx_q == LAST_IDX) ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Serializer outputs: FIFO pop, shift/index updates and the UART strobe.
  always_comb begin
    fifoPop     = 1'b0;
    shift_d     = shift_q;
    byteIdx_d   = byteIdx_q;
    uartData_d  = uartData_q;
    uartStart_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          shift_d   = fifoHead;
          byteIdx_d = '0;
        end
      end
      LOAD: begin
        uartData_d = shift_q[BLOCK_W-1 -: BYTE_W];
        if (!uart_busy) uartStart_d = 1'b1;
      end
      WAIT: begin
        if (!uart_busy) begin
          shift_d   = {shift_q[BLOCK_W-BYTE_W-1:0], BYTE_W'(0)};
          byteIdx_d = byteIdx_q + IDX_ONE;
        end
      end
      default: ;
    endcase
  end

  // Full flag for the next cycle: a refused write never changes the count.
  always_comb begin
    if (fifoFull) overflow_d = !fifoPop;
    else          overflow_d = (fifoCount == ALMOST_CNT) && tx_write && !fifoPop;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q     <= '0;
      byteIdx_q   <= '0;
      uartData_q  <= '0;
      uartStart_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      byteIdx_q   <= byteIdx_d;
      uartData_q  <= uartData_d;
      uartStart_q <= uartStart_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef TX_DROP_COUNT_EN
  logic [15:0] dropCount_q;

  assign drop_count = dropCount_q;

  // Count writes refused while full, saturating at all ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      dropCount_q <= '0;
    else if (tx_write && fifoFull && (dropCount_q != 16'hFFFF))
      dropCount_q <= dropCount_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_tx_block_serializer.sv
// Directed bench for tx_block_serializer with a simple UART busy model.
// Also exercises drop_count when built with TX_DROP_COUNT_EN.
module tb_tx_block_serializer;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [127:0] ct = '0;
  logic         tx_write = 1'b0;
  logic         tx_overflow;
  logic [7:0]   uart_data;
  logic         uart_start;
  logic         uart_busy = 1'b0;
  logic         tx_idle;
`ifdef TX_DROP_COUNT_EN
  logic [15:0]  drop_count;
`endif

  int vecCount = 0;
  int missCount = 0;
  int busyLen = 1;
  bit forceBusy = 1'b0;
  int busyCnt = 0;
  bit pending = 1'b0;
  logic [7:0] capQ[$];

  tx_block_serializer #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .ct          (ct),
    .tx_write    (tx_write),
    .tx_overflow (tx_overflow),
    .uart_data   (uart_data),
    .uart_start  (uart_start),
    .uart_busy   (uart_busy),
    .tx_idle     (tx_idle)
`ifdef TX_DROP_COUNT_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  always #5 clk = ~clk;

  // UART model: captures each start, raises busy the cycle after, for busyLen cycles.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      busyCnt = 0;
      pending = 1'b0;
    end else begin
      if (busyCnt > 0) busyCnt = busyCnt - 1;
      if (pending) begin
        busyCnt = busyLen;
        pending = 1'b0;
      end
      if (uart_start) begin
        pending = 1'b1;
        capQ.push_back(uart_data);
      end
    end
    uart_busy = forceBusy || (busyCnt > 0);
  end

  // Watchdog against a stuck run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  // Block whose byte j is {k, j}, making every byte of every block distinct.
  function automatic logic [127:0] mkBlock(input logic [3:0] k);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[127-8*j -: 8] = {k, 4'(j)};
    return r;
  endfunction

  // Drives one write strobe; called at a negedge, returns at the next negedge.
  task automatic writeBlock(input logic [127:0] d);
    ct = d;
    tx_write = 1'b1;
    @(negedge clk);
    tx_write = 1'b0;
  endtask

  task automatic waitBytes(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (capQ.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (capQ.size() < n) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL %s_timeout: got %0d bytes, expected %0d", name, capQ.size(), n);
    end
  endtask

  task automatic waitIdle(input int budget);
    int c;
    c = 0;
    while (!tx_idle && c < budget) begin
      @(negedge clk);
      c++;
    end
    vecCount++;
    if (tx_idle !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL idle_timeout: got tx_idle=%b, expected 1", tx_idle);
    end
    repeat (15) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    vecCount++; if (uart_start !== 1'b0) begin missCount++; $display("[TB] FAIL rst_start: got %b, expected 0", uart_start); end
    vecCount++; if (uart_data !== 8'h00) begin missCount++; $display("[TB] FAIL rst_data: got %h, expected 00", uart_data); end
    vecCount++; if (tx_idle !== 1'b1) begin missCount++; $display("[TB] FAIL rst_idle: got %b, expected 1", tx_idle); end
    vecCount++; if (tx_overflow !== 1'b0) begin missCount++; $display("[TB] FAIL rst_overflow: got %b, expected 0", tx_overflow); end
`ifdef TX_DROP_COUNT_EN
    vecCount++; if (drop_count !== 16'h0) begin missCount++; $display("[TB] FAIL rst_drop: got %h, expected 0000", drop_count); end
`endif
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_block();
    busyLen = 10;
    forceBusy = 1'b0;
    capQ.delete();
    writeBlock(128'h000102030405060708090A0B0C0D0E0F);
    vecCount++; if (uart_start !== 1'b0) begin missCount++; $display("[TB] FAIL lat_early: got start=%b, expected 0", uart_start); end
    @(negedge clk);
    vecCount++; if (uart_start !== 1'b0) begin missCount++; $display("[TB] FAIL lat_early2: got start=%b, expected 0", uart_start); end
    @(negedge clk);
    vecCount++; if (uart_start !== 1'b1) begin missCount++; $display("[TB] FAIL lat_first: got start=%b, expected 1", uart_start); end
    vecCount++; if (uart_data !== 8'h00) begin missCount++; $display("[TB] FAIL lat_data: got %h, expected 00", uart_data); end
    waitBytes(16, 400, "single");
    repeat (30) @(negedge clk);
    vecCount++; if (capQ.size() !== 16) begin missCount++; $display("[TB] FAIL single_count: got %0d, expected 16", capQ.size()); end
    for (int n = 0; n < 16 && n < capQ.size(); n++) begin
      vecCount++;
      if (capQ[n] !== 8'(n)) begin missCount++; $display("[TB] FAIL single_byte%0d: got %h, expected %h", n, capQ[n], 8'(n)); end
    end
    vecCount++; if (tx_idle !== 1'b1) begin missCount++; $display("[TB] FAIL single_idle: got %b, expected 1", tx_idle); end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] e;
    capQ.delete();
    forceBusy = 1'b1;
    busyLen = 1;
    writeBlock(mkBlock(4'd1));
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      writeBlock(mkBlock(4'(i + 2)));
      vecCount++;
      if (tx_overflow !== (i >= 3)) begin
        missCount++;
        $display("[TB] FAIL fill_ovf%0d: got %b, expected %b", i, tx_overflow, (i >= 3));
      end
    end
`ifdef TX_DROP_COUNT_EN
    vecCount++; if (drop_count !== 16'd2) begin missCount++; $display("[TB] FAIL fill_drop: got %0d, expected 2", drop_count); end
`endif
    forceBusy = 1'b0;
    waitBytes(80, 1000, "fill");
    waitIdle(200);
    vecCount++; if (capQ.size() !== 80) begin missCount++; $display("[TB] FAIL fill_count: got %0d, expected 80", capQ.size()); end
    for (int n = 0; n < 80 && n < capQ.size(); n++) begin
      e = {4'(1 + n / 16), 4'(n % 16)};
      vecCount++;
      if (capQ[n] !== e) begin missCount++; $display("[TB] FAIL fill_byte%0d: got %h, expected %h", n, capQ[n], e); end
    end
    vecCount++; if (tx_overflow !== 1'b0) begin missCount++; $display("[TB] FAIL fill_ovf_end: got %b, expected 0", tx_overflow); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] e;
    capQ.delete();
    forceBusy = 1'b1;
    busyLen = 1;
    writeBlock(mkBlock(4'd8));
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) writeBlock(mkBlock(4'(i + 9)));
    vecCount++; if (tx_overflow !== 1'b1) begin missCount++; $display("[TB] FAIL sim_full: got %b, expected 1", tx_overflow); end
    forceBusy = 1'b0;
    waitBytes(16, 300, "sim_prime");
    forceBusy = 1'b1;
    repeat (5) @(negedge clk);
    vecCount++; if (tx_overflow !== 1'b1) begin missCount++; $display("[TB] FAIL sim_hold: got %b, expected 1", tx_overflow); end
    forceBusy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ct = mkBlock(4'd13);
    tx_write = 1'b1;
    vecCount++; if (tx_overflow !== 1'b1) begin missCount++; $display("[TB] FAIL sim_prepop: got %b, expected 1", tx_overflow); end
    @(negedge clk);
    tx_write = 1'b0;
    vecCount++; if (tx_overflow !== 1'b0) begin missCount++; $display("[TB] FAIL sim_postpop: got %b, expected 0", tx_overflow); end
`ifdef TX_DROP_COUNT_EN
    vecCount++; if (drop_count !== 16'd3) begin missCount++; $display("[TB] FAIL sim_drop: got %0d, expected 3", drop_count); end
`endif
    waitBytes(80, 1000, "sim");
    waitIdle(200);
    vecCount++; if (capQ.size() !== 80) begin missCount++; $display("[TB] FAIL sim_count: got %0d, expected 80", capQ.size()); end
    for (int n = 0; n < 80 && n < capQ.size(); n++) begin
      e = {4'(8 + n / 16), 4'(n % 16)};
      vecCount++;
      if (capQ[n] !== e) begin missCount++; $display("[TB] FAIL sim_byte%0d: got %h, expected %h", n, capQ[n], e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    capQ.delete();
    busyLen = 2;
    writeBlock({16{8'hAA}});
    writeBlock({16{8'h55}});
    waitBytes(32, 600, "b2b");
    waitIdle(200);
    vecCount++; if (capQ.size() !== 32) begin missCount++; $display("[TB] FAIL b2b_count: got %0d, expected 32", capQ.size()); end
    for (int n = 0; n < 32 && n < capQ.size(); n++) begin
      e = (n < 16) ? 8'hAA : 8'h55;
      vecCount++;
      if (capQ[n] !== e) begin missCount++; $display("[TB] FAIL b2b_byte%0d: got %h, expected %h", n, capQ[n], e); end
    end
  endtask

  task automatic test_reset_mid_block();
    int sizeAtRelease;
    capQ.delete();
    busyLen = 3;
    writeBlock(mkBlock(4'd14));
    waitBytes(5, 200, "rstmid");
    reset = 1'b0;
    #1;
    vecCount++; if (uart_start !== 1'b0) begin missCount++; $display("[TB] FAIL rstmid_start: got %b, expected 0", uart_start); end
    vecCount++; if (uart_data !== 8'h00) begin missCount++; $display("[TB] FAIL rstmid_data: got %h, expected 00", uart_data); end
    vecCount++; if (tx_idle !== 1'b1) begin missCount++; $display("[TB] FAIL rstmid_idle: got %b, expected 1", tx_idle); end
    vecCount++; if (tx_overflow !== 1'b0) begin missCount++; $display("[TB] FAIL rstmid_ovf: got %b, expected 0", tx_overflow); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sizeAtRelease = capQ.size();
    repeat (40) @(negedge clk);
    vecCount++; if (capQ.size() !== sizeAtRelease) begin missCount++; $display("[TB] FAIL rstmid_quiet: got %0d bytes, expected %0d", capQ.size(), sizeAtRelease); end
    vecCount++; if (tx_idle !== 1'b1) begin missCount++; $display("[TB] FAIL rstmid_idle2: got %b, expected 1", tx_idle); end
  endtask

  task automatic test_pointer_wrap();
    logic [127:0] wb[10];
    logic [127:0] t;
    logic [7:0]   e;
    int gap;
    capQ.delete();
    busyLen = 1;
    for (int i = 0; i < 10; i++) begin
      wb[i] = {$urandom, $urandom, $urandom, $urandom};
      writeBlock(wb[i]);
      gap = $urandom_range(50, 80);
      repeat (gap - 1) @(negedge clk);
    end
    waitBytes(160, 3000, "wrap");
    waitIdle(300);
    vecCount++; if (capQ.size() !== 160) begin missCount++; $display("[TB] FAIL wrap_count: got %0d, expected 160", capQ.size()); end
    for (int n = 0; n < 160 && n < capQ.size(); n++) begin
      t = wb[n / 16];
      e = t[127 - 8 * (n % 16) -: 8];
      vecCount++;
      if (capQ[n] !== e) begin missCount++; $display("[TB] FAIL wrap_byte%0d: got %h, expected %h", n, capQ[n], e); end
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_fill_overflow();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_block();
    test_pointer_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
